// File: rtl/spectrum_bar_buffer_if.sv
// Magnitude stream from the FFT magnitude stage into the bar buffer.
// A sample moves on a clock where i_mag_valid and o_mag_ready are both high.
//   i_mag        : FFT bin magnitude, unsigned
//   i_mag_valid  : i_mag / i_mag_last are valid
//   i_mag_last   : final bin of an FFT frame
//   o_mag_ready  : buffer accepts a sample
// Modports: master = sample source, slave = spectrum_bar_buffer.
interface spectrum_bar_buffer_if #(
   parameter int unsigned IN_W = 16
) ();
   logic [IN_W-1:0] i_mag;
   logic            i_mag_valid;
   logic            i_mag_last;
   logic            o_mag_ready;

   modport master (output i_mag, output i_mag_valid, output i_mag_last, input o_mag_ready);
   modport slave  (input i_mag, input i_mag_valid, input i_mag_last, output o_mag_ready);
endinterface

// File: rtl/spectrum_bar_buffer.sv
// Double-buffered spectrum bar heights. FFT bin magnitudes are merged
// BINS_PER_BAR at a time (running max), scaled to pixels and saturated into a
// back buffer. A completed frame is swapped into the front buffer on the next
// rising edge of the renderer's vsync, so the renderer sees stable heights.
// Ports:
//   i_clk         : clock, rising edge
//   i_reset       : synchronous, active-low reset
//   mag_if        : magnitude stream (slave modport)
//   i_vsync       : renderer vertical-sync level
//   o_bar_height  : front-buffer heights, bar k at [k*H_W +: H_W]
//   o_frame_done  : one-cycle pulse when the front buffer is updated
//   o_frame_err   : sticky, a frame had the wrong length
// Optional macro BAR_PEAK_HOLD_EN: front bars fall by at most DECAY per swap.
module spectrum_bar_buffer #(
   parameter int unsigned NUM_BARS     = 16,
   parameter int unsigned BINS_PER_BAR = 4,
   parameter int unsigned IN_W         = 16,
   parameter int unsigned H_W          = 10,
   parameter int unsigned SHIFT        = 6,
   parameter int unsigned MAX_H        = 480,
   parameter int unsigned DECAY        = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   spectrum_bar_buffer_if.slave    mag_if,
   input  logic                    i_vsync,
   output logic [NUM_BARS*H_W-1:0] o_bar_height,
   output logic                    o_frame_done,
   output logic                    o_frame_err
);

   localparam int unsigned BIN_W = (BINS_PER_BAR > 1) ? $clog2(BINS_PER_BAR) : 1;
   localparam int unsigned BAR_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

   // Heights and decay step must be representable in H_W bits.
   if (MAX_H >= (32'd1 << H_W) || DECAY >= (32'd1 << H_W)) begin : g_cfg_check
      $error("spectrum_bar_buffer: MAX_H or DECAY does not fit in H_W bits");
   end

   typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [BAR_W-1:0] bar_q, bar_d;
   logic [IN_W-1:0]  max_q, max_d;
   logic [H_W-1:0]   back_q  [NUM_BARS];
   logic [H_W-1:0]   back_d  [NUM_BARS];
   logic [H_W-1:0]   front_q [NUM_BARS];
   logic [H_W-1:0]   front_d [NUM_BARS];
   logic             vsync_q;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             xfer_c;
   logic             vsync_edge_c;
   logic             bin_last_c;
   logic             bar_last_c;
   logic [IN_W-1:0]  cur_max_c;

   // Scale a magnitude to pixels and saturate at MAX_H.
   function automatic logic [H_W-1:0] to_height(input logic [IN_W-1:0] m);
      logic [IN_W-1:0] s;
      s = m >> SHIFT;
      if (s > IN_W'(MAX_H)) return H_W'(MAX_H);
      return H_W'(s);
   endfunction

   assign xfer_c       = mag_if.i_mag_valid & ready_q;
   assign vsync_edge_c = i_vsync & ~vsync_q;
   assign bin_last_c   = (bin_q == BIN_W'(BINS_PER_BAR - 1));
   assign bar_last_c   = (bar_q == BAR_W'(NUM_BARS - 1));
   assign cur_max_c    = (mag_if.i_mag > max_q) ? mag_if.i_mag : max_q;

   // Next-state and datapath update.
   always_comb begin
`ifdef BAR_PEAK_HOLD_EN
      logic [H_W-1:0] dec;
      dec = '0;
`endif
      state_d = state_q;
      bin_d   = bin_q;
      bar_d   = bar_q;
      max_d   = max_q;
      back_d  = back_q;
      front_d = front_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         ACCUM: begin
            if (xfer_c) begin
               if (bin_last_c || mag_if.i_mag_last) back_d[bar_q] = to_height(cur_max_c);
               if (mag_if.i_mag_last) begin
                  // Short frame: bars never reached read as empty.
                  for (int unsigned k = 0; k < NUM_BARS; k++)
                     if (k > 32'(bar_q)) back_d[k] = '0;
                  if (!(bin_last_c && bar_last_c)) err_d = 1'b1;
                  state_d = HOLD;
                  bin_d   = '0;
                  bar_d   = '0;
                  max_d   = '0;
               end else if (bin_last_c && bar_last_c) begin
                  // Buffer full but no frame end yet: flush the rest.
                  err_d   = 1'b1;
                  state_d = DRAIN;
                  bin_d   = '0;
                  bar_d   = '0;
                  max_d   = '0;
               end else if (bin_last_c) begin
                  bin_d = '0;
                  bar_d = bar_q + BAR_W'(1);
                  max_d = '0;
               end else begin
                  bin_d = bin_q + BIN_W'(1);
                  max_d = cur_max_c;
               end
            end
         end
         DRAIN: begin
            if (xfer_c && mag_if.i_mag_last) state_d = HOLD;
         end
         HOLD: begin
            if (vsync_edge_c) begin
               for (int unsigned k = 0; k < NUM_BARS; k++) begin
`ifdef BAR_PEAK_HOLD_EN
                  dec = (front_q[k] > H_W'(DECAY)) ? front_q[k] - H_W'(DECAY) : '0;
                  front_d[k] = (back_q[k] > dec) ? back_q[k] : dec;
`else
                  front_d[k] = back_q[k];
`endif
               end
               done_d  = 1'b1;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase

      ready_d = (state_d != HOLD);
   end

   // State and datapath registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= ACCUM;
         bin_q   <= '0;
         bar_q   <= '0;
         max_q   <= '0;
         back_q  <= '{default: '0};
         front_q <= '{default: '0};
         vsync_q <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bar_q   <= bar_d;
         max_q   <= max_d;
         back_q  <= back_d;
         front_q <= front_d;
         vsync_q <= i_vsync;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   for (genvar k = 0; k < NUM_BARS; k++) begin : g_pack
      assign o_bar_height[k*H_W +: H_W] = front_q[k];
   end

   assign mag_if.o_mag_ready = ready_q;
   assign o_frame_done       = done_q;
   assign o_frame_err        = err_q;

endmodule

// File: tb/tb_spectrum_bar_buffer.sv
// Directed bench for spectrum_bar_buffer: full frame, saturation and bar max,
// ignored vsync, short frame, reset mid-frame, overlong frame, peak/decay run.
module tb_spectrum_bar_buffer;
   localparam int unsigned NB = 16;
   localparam int unsigned HW = 10;
   localparam int unsigned BW = NB * HW;

   logic          clk = 1'b0;
   logic          reset;
   logic          vsync;
   logic [BW-1:0] bar_height;
   logic          frame_done;
   logic          frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [HW-1:0] exp_back  [NB];
   logic [HW-1:0] exp_front [NB];

   spectrum_bar_buffer_if #(.IN_W(16)) mag_if ();

   spectrum_bar_buffer dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .mag_if       (mag_if),
      .i_vsync      (vsync),
      .o_bar_height (bar_height),
      .o_frame_done (frame_done),
      .o_frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] pack_front();
      logic [BW-1:0] v;
      v = '0;
      for (int k = 0; k < NB; k++) v[k*HW +: HW] = exp_front[k];
      return v;
   endfunction

   function automatic logic [15:0] t2_mag(input int i);
      if (i == 14) return 16'hFFFF;
      case (i)
         20: return 16'd100;
         21: return 16'd5000;
         22: return 16'd200;
         23: return 16'd300;
         default: return 16'((i / 4 + 1) * 64);
      endcase
   endfunction

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] m, input logic l, input logic vs);
      mag_if.i_mag       = m;
      mag_if.i_mag_valid = 1'b1;
      mag_if.i_mag_last  = l;
      vsync              = vs;
      @(posedge clk); #1;
      mag_if.i_mag_valid = 1'b0;
      mag_if.i_mag_last  = 1'b0;
      vsync              = 1'b0;
   endtask

   // Expected swap result, then vsync edge and pulse/height checks.
   task automatic swap(input string tag);
      for (int k = 0; k < NB; k++) begin
`ifdef BAR_PEAK_HOLD_EN
         logic [HW-1:0] dec;
         dec = (exp_front[k] > HW'(8)) ? exp_front[k] - HW'(8) : '0;
         exp_front[k] = (exp_back[k] > dec) ? exp_back[k] : dec;
`else
         exp_front[k] = exp_back[k];
`endif
      end
      vsync = 1'b1;
      @(posedge clk); #1;
      vsync = 1'b0;
      check({tag, "_done"},   BW'(frame_done), BW'(1));
      check({tag, "_height"}, bar_height, pack_front());
      @(posedge clk); #1;
      check({tag, "_done_off"}, BW'(frame_done), BW'(0));
      check({tag, "_ready"},    BW'(mag_if.o_mag_ready), BW'(1));
   endtask

   initial begin
      logic saw;
      reset              = 1'b0;
      vsync              = 1'b0;
      mag_if.i_mag       = '0;
      mag_if.i_mag_valid = 1'b0;
      mag_if.i_mag_last  = 1'b0;
      for (int k = 0; k < NB; k++) begin
         exp_back[k]  = '0;
         exp_front[k] = '0;
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_height", bar_height, '0);
      check("rst_done",   BW'(frame_done), BW'(0));
      check("rst_err",    BW'(frame_err), BW'(0));
      check("rst_ready",  BW'(mag_if.o_mag_ready), BW'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      check("rel_ready", BW'(mag_if.o_mag_ready), BW'(1));

      // T1: bar k bins all (k+1)*64, exact length
      for (int i = 0; i < 64; i++) send(16'((i / 4 + 1) * 64), i == 63, 1'b0);
      for (int k = 0; k < NB; k++) exp_back[k] = HW'(k + 1);
      check("t1_hold_ready", BW'(mag_if.o_mag_ready), BW'(0));
      check("t1_err",        BW'(frame_err), BW'(0));
      check("t1_no_swap",    bar_height, '0);

      // Long wait in HOLD with valid asserted: nothing accepted
      mag_if.i_mag       = 16'hFFFF;
      mag_if.i_mag_valid = 1'b1;
      mag_if.i_mag_last  = 1'b1;
      saw = 1'b0;
      repeat (1000) begin
         @(posedge clk); #1;
         saw = saw | mag_if.o_mag_ready | frame_done;
      end
      mag_if.i_mag_valid = 1'b0;
      mag_if.i_mag_last  = 1'b0;
      check("idle_ready_or_done", BW'(saw), BW'(0));
      check("idle_height",        bar_height, '0);
      swap("t1");
      check("t1_err_after", BW'(frame_err), BW'(0));

      // T2: saturation, bar max, vsync ignored in ACCUM, vsync on HOLD entry
      for (int i = 0; i < 64; i++) begin
         if (i == 32) begin
            vsync = 1'b1;
            @(posedge clk); #1;
            vsync = 1'b0;
            check("t2_accum_vsync_done",   BW'(frame_done), BW'(0));
            check("t2_accum_vsync_height", bar_height, pack_front());
            @(posedge clk); #1;
         end
         send(t2_mag(i), i == 63, i == 63);
      end
      check("t2_entry_done",  BW'(frame_done), BW'(0));
      check("t2_entry_ready", BW'(mag_if.o_mag_ready), BW'(0));
      @(posedge clk); #1;
      check("t2_entry_done2",  BW'(frame_done), BW'(0));
      check("t2_entry_height", bar_height, pack_front());
      for (int k = 0; k < NB; k++) exp_back[k] = HW'(k + 1);
      exp_back[3] = HW'(480);
      exp_back[5] = HW'(78);
      swap("t2");

      // T3: frame ends on transfer 10
      for (int i = 0; i < 10; i++)
         send((i < 4) ? 16'd640 : (i < 8) ? 16'd1280 : (i == 8) ? 16'd3200 : 16'd1920,
              i == 9, 1'b0);
      check("t3_ready", BW'(mag_if.o_mag_ready), BW'(0));
      check("t3_err",   BW'(frame_err), BW'(1));
      for (int k = 0; k < NB; k++) exp_back[k] = '0;
      exp_back[0] = HW'(10);
      exp_back[1] = HW'(20);
      exp_back[2] = HW'(50);
      swap("t3");
      check("t3_err_sticky", BW'(frame_err), BW'(1));

      // T4: reset mid-frame, then a 70-sample frame
      for (int i = 0; i < 5; i++) send(16'hFFFF, 1'b0, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int k = 0; k < NB; k++) begin
         exp_back[k]  = '0;
         exp_front[k] = '0;
      end
      check("t4_rst_height", bar_height, '0);
      check("t4_rst_err",    BW'(frame_err), BW'(0));
      for (int i = 1; i <= 70; i++) begin
         check("t4_ready", BW'(mag_if.o_mag_ready), BW'(1));
         send(16'd448, i == 70, 1'b0);
         if (i == 63) check("t4_err_63", BW'(frame_err), BW'(0));
         if (i == 64) check("t4_err_64", BW'(frame_err), BW'(1));
      end
      check("t4_ready_after", BW'(mag_if.o_mag_ready), BW'(0));
      check("t4_err",         BW'(frame_err), BW'(1));
      for (int k = 0; k < NB; k++) exp_back[k] = HW'(7);
      swap("t4");

      // T5: bar 0 = 100, then empty frames, then 5
      for (int k = 0; k < NB; k++) exp_back[k] = '0;
      send(16'd6400, 1'b1, 1'b0);
      exp_back[0] = HW'(100);
      swap("t5_100");
      exp_back[0] = '0;
      for (int j = 0; j < 12; j++) begin
         send(16'd0, 1'b1, 1'b0);
         swap("t5_decay");
      end
      send(16'd320, 1'b1, 1'b0);
      exp_back[0] = HW'(5);
      swap("t5_five");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
